// File: rtl/mastermind_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mastermind_game_ctrl                                             |
// | Brief   : MasterMind game sequencer: guess editing, sequential scoring,    |
// |           guess counting and packed 4x5-bit display drive.                 |
// |           Optional MM_LFSR_SECRET_EN: LFSR-generated secret + WON blink.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mastermind_game_ctrl #(
    parameter int NUM_COLORS  = 6,
    parameter int MAX_GUESSES = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SECRET_LOAD,
    input  logic [15:0] SECRET_IN,
    input  logic        BTN_NEXT,
    input  logic        BTN_INC,
    input  logic        BTN_SUBMIT,
    output logic [19:0] DISP_VALS,
    output logic [2:0]  SCORE_EXACT,
    output logic [2:0]  SCORE_PARTIAL,
    output logic        SCORE_VALID,
    output logic [3:0]  GUESS_NUM,
    output logic        BUSY,
    output logic        WON,
    output logic        LOST
);

    localparam logic [4:0] c_NUM_COLORS = 5'(NUM_COLORS);
    localparam logic [3:0] c_TOP_COLOR  = 4'(NUM_COLORS - 1);
    localparam logic [4:0] c_LAST_CYC   = 5'(NUM_COLORS + 3);
    localparam logic [3:0] c_MAX_GUESS  = 4'(MAX_GUESSES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EDIT   = 3'd1,
        ST_SCORE  = 3'd2,
        ST_RESULT = 3'd3,
        ST_WON    = 3'd4,
        ST_LOST   = 3'd5
    } state_t;

    state_t      r_state;
    logic [3:0]  r_secret [4];
    logic [3:0]  r_guess  [4];
    logic [1:0]  r_cursor;
    logic [3:0]  r_guess_num;
    logic [2:0]  r_score_exact;
    logic [2:0]  r_score_partial;
    logic        r_score_valid;
    logic [4:0]  r_cnt;
    logic [2:0]  r_exact_acc;
    logic [2:0]  r_partial_acc;
    logic [2:0]  r_hist_g [16];
    logic [2:0]  r_hist_s [16];
    logic [19:0] r_disp;

    logic        w_auto_load;
    logic        w_load;
    logic [15:0] w_load_val;
    logic        w_won_hl;
    logic [3:0]  w_g;
    logic [3:0]  w_s;
    logic [3:0]  w_color;
    logic [2:0]  w_min;
    logic [2:0]  w_partial_next;
    logic [19:0] w_disp;

    function automatic logic [3:0] sanitize(input logic [3:0] d);
        return ({1'b0, d} < c_NUM_COLORS) ? d : 4'd0;
    endfunction

    function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
        return (a < b) ? a : b;
    endfunction

`ifdef MM_LFSR_SECRET_EN
    logic [15:0] r_lfsr;
    logic [23:0] r_blink_cnt;

    // Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lfsr      <= 16'hACE1;
            r_blink_cnt <= '0;
        end else begin
            r_lfsr      <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_blink_cnt <= r_blink_cnt + 24'd1;
        end
    end

    assign w_auto_load = BTN_SUBMIT &&
                         (r_state == ST_IDLE || r_state == ST_WON || r_state == ST_LOST);
    assign w_load_val  = SECRET_LOAD ? SECRET_IN : r_lfsr;
    assign w_won_hl    = r_blink_cnt[23];
`else
    assign w_auto_load = 1'b0;
    assign w_load_val  = SECRET_IN;
    assign w_won_hl    = 1'b1;
`endif

    assign w_load         = SECRET_LOAD | w_auto_load;
    assign w_g            = r_guess[r_cnt[1:0]];
    assign w_s            = r_secret[r_cnt[1:0]];
    assign w_color        = 4'(r_cnt - 5'd4);
    assign w_min          = min3(r_hist_g[w_color], r_hist_s[w_color]);
    assign w_partial_next = r_partial_acc + w_min;

    always_comb begin
        w_disp = '0;
        case (r_state)
            ST_EDIT: begin
                for (int i = 0; i < 4; i++)
                    w_disp[i*5 +: 5] = {r_cursor == 2'(i), r_guess[i]};
            end
            ST_SCORE: begin
                for (int i = 0; i < 4; i++)
                    w_disp[i*5 +: 5] = {1'b0, r_guess[i]};
            end
            ST_RESULT: begin
                w_disp[4:0] = {2'b10, r_score_exact};
                w_disp[9:5] = {2'b00, r_score_partial};
            end
            ST_WON: begin
                for (int i = 0; i < 4; i++)
                    w_disp[i*5 +: 5] = {w_won_hl, r_secret[i]};
            end
            ST_LOST: begin
                for (int i = 0; i < 4; i++)
                    w_disp[i*5 +: 5] = {1'b0, r_secret[i]};
            end
            default: w_disp = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= ST_IDLE;
            r_cursor        <= '0;
            r_guess_num     <= '0;
            r_score_exact   <= '0;
            r_score_partial <= '0;
            r_score_valid   <= 1'b0;
            r_cnt           <= '0;
            r_exact_acc     <= '0;
            r_partial_acc   <= '0;
            r_disp          <= '0;
            for (int i = 0; i < 4; i++) begin
                r_secret[i] <= '0;
                r_guess[i]  <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                r_hist_g[i] <= '0;
                r_hist_s[i] <= '0;
            end
        end else begin
            r_score_valid <= 1'b0;
            r_disp        <= w_disp;
            if (w_load) begin
                // New game; also aborts a scoring pass in flight
                for (int i = 0; i < 4; i++) begin
                    r_secret[i] <= sanitize(w_load_val[i*4 +: 4]);
                    r_guess[i]  <= '0;
                end
                r_cursor        <= '0;
                r_guess_num     <= '0;
                r_score_exact   <= '0;
                r_score_partial <= '0;
                r_state         <= ST_EDIT;
            end else begin
                case (r_state)
                    ST_EDIT: begin
                        if (BTN_SUBMIT) begin
                            r_guess_num   <= r_guess_num + 4'd1;
                            r_cnt         <= '0;
                            r_exact_acc   <= '0;
                            r_partial_acc <= '0;
                            for (int i = 0; i < 16; i++) begin
                                r_hist_g[i] <= '0;
                                r_hist_s[i] <= '0;
                            end
                            r_state <= ST_SCORE;
                        end else if (BTN_NEXT) begin
                            r_cursor <= r_cursor + 2'd1;
                        end else if (BTN_INC) begin
                            r_guess[r_cursor] <= (r_guess[r_cursor] == c_TOP_COLOR) ?
                                                 4'd0 : r_guess[r_cursor] + 4'd1;
                        end
                    end
                    ST_SCORE: begin
                        // Positions first, then one colour per cycle
                        if (r_cnt < 5'd4) begin
                            if (w_g == w_s) begin
                                r_exact_acc <= r_exact_acc + 3'd1;
                            end else begin
                                r_hist_g[w_g] <= r_hist_g[w_g] + 3'd1;
                                r_hist_s[w_s] <= r_hist_s[w_s] + 3'd1;
                            end
                        end else begin
                            r_partial_acc <= w_partial_next;
                        end
                        if (r_cnt == c_LAST_CYC) begin
                            r_score_exact   <= r_exact_acc;
                            r_score_partial <= w_partial_next;
                            r_score_valid   <= 1'b1;
                            if (r_exact_acc == 3'd4)
                                r_state <= ST_WON;
                            else if (r_guess_num == c_MAX_GUESS)
                                r_state <= ST_LOST;
                            else
                                r_state <= ST_RESULT;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    ST_RESULT: begin
                        if (BTN_SUBMIT || BTN_NEXT || BTN_INC) begin
                            r_cursor <= '0;
                            r_state  <= ST_EDIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign DISP_VALS     = r_disp;
    assign SCORE_EXACT   = r_score_exact;
    assign SCORE_PARTIAL = r_score_partial;
    assign SCORE_VALID   = r_score_valid;
    assign GUESS_NUM     = r_guess_num;
    assign BUSY          = (r_state == ST_SCORE);
    assign WON           = (r_state == ST_WON);
    assign LOST          = (r_state == ST_LOST);

endmodule
`default_nettype wire

// File: tb/tb_mastermind_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mastermind_game_ctrl                                          |
// | Brief   : Directed scoreboard bench for mastermind_game_ctrl.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mastermind_game_ctrl;

    localparam int c_COLORS = 6;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SECRET_LOAD = 1'b0;
    logic [15:0] SECRET_IN = '0;
    logic        BTN_NEXT = 1'b0;
    logic        BTN_INC = 1'b0;
    logic        BTN_SUBMIT = 1'b0;
    logic [19:0] DISP_VALS;
    logic [2:0]  SCORE_EXACT;
    logic [2:0]  SCORE_PARTIAL;
    logic        SCORE_VALID;
    logic [3:0]  GUESS_NUM;
    logic        BUSY;
    logic        WON;
    logic        LOST;

    mastermind_game_ctrl #(
        .NUM_COLORS (c_COLORS),
        .MAX_GUESSES(2)
    ) u_dut (
        .CLK          (CLK),
        .RST          (RST),
        .SECRET_LOAD  (SECRET_LOAD),
        .SECRET_IN    (SECRET_IN),
        .BTN_NEXT     (BTN_NEXT),
        .BTN_INC      (BTN_INC),
        .BTN_SUBMIT   (BTN_SUBMIT),
        .DISP_VALS    (DISP_VALS),
        .SCORE_EXACT  (SCORE_EXACT),
        .SCORE_PARTIAL(SCORE_PARTIAL),
        .SCORE_VALID  (SCORE_VALID),
        .GUESS_NUM    (GUESS_NUM),
        .BUSY         (BUSY),
        .WON          (WON),
        .LOST         (LOST)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] ex;
        logic [2:0] pa;
        logic [3:0] gn;
    } exp_t;

    exp_t q_exp[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_guess[4];
    int   m_cursor;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Score monitor: pops one expectation per SCORE_VALID pulse
    always @(negedge CLK) begin
        if (!RST && SCORE_VALID) begin
            if (q_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_score_valid actual=1 required=0");
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("score_exact", 32'(SCORE_EXACT), 32'(e.ex));
                chk("score_partial", 32'(SCORE_PARTIAL), 32'(e.pa));
                chk("score_guess_num", 32'(GUESS_NUM), 32'(e.gn));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic press_next();
        BTN_NEXT = 1'b1; tick(); BTN_NEXT = 1'b0; tick();
        m_cursor = (m_cursor + 1) % 4;
    endtask

    task automatic press_inc();
        BTN_INC = 1'b1; tick(); BTN_INC = 1'b0; tick();
        m_guess[m_cursor] = (m_guess[m_cursor] + 1) % c_COLORS;
    endtask

    // Button press that leaves RESULT: cursor returns to 0
    task automatic press_wake();
        BTN_NEXT = 1'b1; tick(); BTN_NEXT = 1'b0; tick();
        m_cursor = 0;
    endtask

    // Returns in SCORE cycle 0
    task automatic press_submit(input logic [2:0] ex, input logic [2:0] pa, input logic [3:0] gn);
        q_exp.push_back('{ex: ex, pa: pa, gn: gn});
        BTN_SUBMIT = 1'b1; tick(); BTN_SUBMIT = 1'b0;
    endtask

    task automatic press_load(input logic [15:0] v);
        SECRET_IN = v; SECRET_LOAD = 1'b1; tick(); SECRET_LOAD = 1'b0; tick();
        for (int i = 0; i < 4; i++) m_guess[i] = 0;
        m_cursor = 0;
    endtask

    task automatic set_guess(input logic [15:0] t);
        for (int i = 0; i < 4; i++) begin
            int tgt;
            int delta;
            while (m_cursor != i) press_next();
            tgt   = int'(t[i*4 +: 4]);
            delta = (tgt + c_COLORS - m_guess[i]) % c_COLORS;
            repeat (delta) press_inc();
        end
    endtask

    task automatic wait_score(output int n);
        n = 0;
        while (BUSY && n < 100) begin
            n++;
            tick();
        end
        if (n >= 100) chk("score_timeout", 32'(n), 32'd10);
        tick(); tick();
    endtask

    initial begin
        int n;
        m_cursor = 0;
        for (int i = 0; i < 4; i++) m_guess[i] = 0;
        repeat (3) tick();
        RST = 1'b0;
        tick();

        // Reset state
        chk("rst_disp", 32'(DISP_VALS), 32'h0);
        chk("rst_guess_num", 32'(GUESS_NUM), 32'h0);
        chk("rst_flags", {29'd0, BUSY, WON, LOST}, 32'h0);
        chk("rst_score", {26'd0, SCORE_EXACT, SCORE_PARTIAL}, 32'h0);

        // Buttons ignored in IDLE
        press_inc(); press_next();
        chk("idle_disp", 32'(DISP_VALS), 32'h0);

        // Editing and cursor highlight
        press_load(16'h1234);
        m_guess[1] = 0; m_cursor = 0; m_guess[0] = 0;
        repeat (3) press_inc();
        chk("edit_inc3", 32'(DISP_VALS), 32'h00013);
        press_next();
        chk("edit_next", 32'(DISP_VALS), 32'h00203);

        // Secret 1234, guess 4321 -> 0 exact, 4 partial
        set_guess(16'h4321);
        press_submit(3'd0, 3'd4, 4'd1);
        wait_score(n);
        chk("busy_cycles", 32'(n), 32'd10);
        chk("result_disp", 32'(DISP_VALS), 32'h00090);
        chk("result_flags", {30'd0, WON, LOST}, 32'h0);

        // Secret 1123: guess 1311 -> 1/2, then guess 1123 -> win
        press_load(16'h1123);
        set_guess(16'h1311);
        press_submit(3'd1, 3'd2, 4'd1);
        wait_score(n);
        press_wake();
        set_guess(16'h1123);
        press_submit(3'd4, 3'd0, 4'd2);
        wait_score(n);
        chk("won_flags", {30'd0, WON, LOST}, 32'h2);
        chk("won_disp", 32'(DISP_VALS), 32'({5'h11, 5'h11, 5'h12, 5'h13}));

        // Two wrong guesses -> LOST, buttons inert
        press_load(16'h1234);
        press_submit(3'd0, 3'd0, 4'd1);
        wait_score(n);
        press_wake();
        press_submit(3'd0, 3'd0, 4'd2);
        wait_score(n);
        chk("lost_flags", {30'd0, WON, LOST}, 32'h1);
        chk("lost_guess_num", 32'(GUESS_NUM), 32'd2);
        chk("lost_disp", 32'(DISP_VALS), 32'({5'd1, 5'd2, 5'd3, 5'd4}));
        press_inc(); press_next();
        BTN_SUBMIT = 1'b1; tick(); BTN_SUBMIT = 1'b0;
        repeat (15) tick();
        chk("lost_hold_flags", {29'd0, BUSY, WON, LOST}, 32'h1);
        chk("lost_hold_disp", 32'(DISP_VALS), 32'({5'd1, 5'd2, 5'd3, 5'd4}));

        // Out-of-range secret digit stored as 0: guess 0000 wins
        press_load(16'hF000);
        press_submit(3'd4, 3'd0, 4'd1);
        wait_score(n);
        chk("sanitize_won", 32'(WON), 32'h1);
        chk("sanitize_disp", 32'(DISP_VALS), 32'({5'h10, 5'h10, 5'h10, 5'h10}));

        // Digit wraps NUM_COLORS-1 -> 0
        press_load(16'h1234);
        repeat (5) press_inc();
        chk("wrap_top", 32'(DISP_VALS), 32'h00015);
        press_inc();
        chk("wrap_zero", 32'(DISP_VALS), 32'h00010);

        // SECRET_LOAD in SCORE cycle 3 aborts scoring (no expectation pushed)
        BTN_SUBMIT = 1'b1; tick(); BTN_SUBMIT = 1'b0;
        repeat (3) tick();
        SECRET_IN = 16'h1234; SECRET_LOAD = 1'b1; tick(); SECRET_LOAD = 1'b0;
        chk("abort_busy", 32'(BUSY), 32'h0);
        chk("abort_guess_num", 32'(GUESS_NUM), 32'h0);
        repeat (15) tick();
        chk("abort_disp", 32'(DISP_VALS), 32'h00010);

        // SUBMIT with INC in the same cycle: INC dropped, guess stays 0000
        BTN_INC = 1'b1;
        press_submit(3'd0, 3'd0, 4'd1);
        BTN_INC = 1'b0;
        wait_score(n);
        chk("submit_inc_guess_num", 32'(GUESS_NUM), 32'd1);

        repeat (3) tick();
        chk("scoreboard_drained", 32'(q_exp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mastermind_game_ctrl.md
Name: mastermind_game_ctrl

Overview:
Game sequencer for the 4-digit MasterMind board. It holds the secret code and the player's guess, and takes edit commands from the debounced, edge-detected button pulses. On submit it scores the guess sequentially (exact and colour-only matches), tracks the guess count and drives the packed 4x5-bit digit vector consumed by the segment display driver. It sits between the button edge detectors and SegmentDisplay, replacing ad-hoc value editing in the top level.

Parameters:
NUM_COLORS, 6, number of legal digit values 0..NUM_COLORS-1; legal range 2..16
MAX_GUESSES, 10, guesses allowed before LOST; legal range 1..15

Ports:
CLK  in  1  system clock (PLL domain)
RST  in  1  synchronous, active-high reset
SECRET_LOAD  in  1  one-cycle pulse: load SECRET_IN and start a new game
SECRET_IN  in  16  secret {d3,d2,d1,d0}, 4 bits per digit
BTN_NEXT  in  1  one-cycle pulse: move cursor
BTN_INC  in  1  one-cycle pulse: increment digit under cursor
BTN_SUBMIT  in  1  one-cycle pulse: score current guess
DISP_VALS  out  20  {v3,v2,v1,v0}; each v = {highlight, digit[3:0]}
SCORE_EXACT  out  3  right colour, right position (0..4)
SCORE_PARTIAL  out  3  right colour, wrong position (0..4)
SCORE_VALID  out  1  one-cycle pulse when the score is updated
GUESS_NUM  out  4  guesses submitted in the current game
BUSY  out  1  high while in SCORE
WON  out  1  high in WON state
LOST  out  1  high in LOST state

Behaviour:
- Reset: state IDLE; secret, guess, cursor, GUESS_NUM, SCORE_* = 0; SCORE_VALID, BUSY, WON, LOST = 0; DISP_VALS = 0.
- Priority every cycle: RST > SECRET_LOAD > BTN_SUBMIT > BTN_NEXT > BTN_INC. At most one button acts per cycle; lower-priority pulses in the same cycle are dropped.
- SECRET_LOAD, in any state including mid-SCORE (aborts scoring):
  - Each digit >= NUM_COLORS is stored as 0.
  - Guess and cursor are cleared to 0; GUESS_NUM and SCORE_* are cleared.
  - Next state is EDIT.
- IDLE: buttons are ignored. DISP_VALS = 0.
- EDIT:
  - BTN_NEXT: cursor = cursor+1 mod 4.
  - BTN_INC: guess[cursor] += 1, wrapping NUM_COLORS-1 -> 0.
  - BTN_SUBMIT: GUESS_NUM += 1; clear the histograms and counters; go to SCORE.
  - DISP_VALS shows the guess digits, with the highlight bit set only on the cursor digit.
- SCORE: lasts exactly 4+NUM_COLORS cycles; BUSY = 1; buttons are ignored.
  - Cycles 0..3 (position i): if guess[i]==secret[i], exact++; else histG[guess[i]]++ and histS[secret[i]]++.
  - Cycles 4..: for each colour c, partial += min(histG[c], histS[c]).
  - Histogram counters are 3 bits each.
  - On the last cycle, register SCORE_EXACT and SCORE_PARTIAL and pulse SCORE_VALID on the next cycle.
  - Next state: WON if exact==4; else LOST if GUESS_NUM==MAX_GUESSES; else RESULT.
  - DISP_VALS holds the guess with no highlight.
- RESULT: DISP_VALS = {0, 0, {0,SCORE_PARTIAL}, {1,SCORE_EXACT}}. Any button pulse returns to EDIT; the guess is retained and cursor = 0.
- WON / LOST: DISP_VALS shows the secret. WON blinks all highlight bits; LOST has no highlight. Buttons are ignored; only SECRET_LOAD or RST leaves these states.
- Invariant: SCORE_EXACT + SCORE_PARTIAL <= 4.

Optional Feature:
MM_LFSR_SECRET_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on RST) advances every cycle.
  - BTN_SUBMIT in IDLE, WON or LOST acts as SECRET_LOAD, using the LFSR state as SECRET_IN with the same out-of-range-to-0 rule.
  - In WON the blink uses bit 23 of a free-running counter.
- Undefined:
  - No LFSR.
  - BTN_SUBMIT is ignored outside EDIT and RESULT.
  - The WON display uses static highlight on all digits.

Test Plan:
- RST; SECRET_LOAD with 16'h1234; 3x BTN_INC -> DISP_VALS v0 = {1,4'h3}, others {0,0}; BTN_NEXT -> highlight moves to v1.
- Secret 1234, guess 4321, BTN_SUBMIT -> BUSY for 10 cycles, then SCORE_VALID with EXACT=0 and PARTIAL=4, state RESULT.
- Secret 1123, guess 1311 -> EXACT=1, PARTIAL=2; guess 1123 -> EXACT=4 and WON=1.
- MAX_GUESSES=2, two wrong submits -> LOST=1, GUESS_NUM=2, DISP_VALS shows the secret, buttons have no effect.
- BTN_INC six times on one digit with NUM_COLORS=6 -> digit returns to 0; SECRET_IN digit 4'hF -> stored as 0.
- SECRET_LOAD asserted during SCORE cycle 3 -> no SCORE_VALID, state EDIT, GUESS_NUM=0; BTN_SUBMIT and BTN_INC in the same cycle -> only the submit acts.
